// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC PC sequencer: FSM states, pc_src
// encodings, reset PC and a small alignment helper.
package npc_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_UPD  = 2'd3
  } state_e;

  localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
  localparam logic [2:0] PC_SRC_JAL    = 3'd1;
  localparam logic [2:0] PC_SRC_JALR   = 3'd2;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd3;
  localparam logic [2:0] PC_SRC_AUIPC  = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Fetch request/response handshake between the PC sequencer (master) and
// the instruction fetch unit (slave).
interface pc_seq_ctrl_if #(
  parameter int XLEN = 32
);

  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_req_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_inst;
  logic            ifu_rsp_ready;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    output ifu_rsp_ready,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_inst
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    input  ifu_rsp_ready,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_inst
  );

endinterface

// File: rtl/npc_target_sel.sv
// Combinational next-PC selection with ecall/mret priority and a
// misalignment flag for the non-trap-vector sources.
module npc_target_sel
  import npc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      pc_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ext_imm,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_rel;
  logic [XLEN-1:0] w_jalr;

  assign w_seq  = pc + 32'd4;
  assign w_rel  = pc + ext_imm;
  assign w_jalr = alu_result & ~32'd1;

  // Priority select; mtvec/mepc are taken as-is and never flag misalignment.
  always_comb begin
    target   = w_seq;
    misalign = 1'b0;
    if (is_ecall) begin
      target = mtvec;
    end else if (is_mret) begin
      target = mepc;
    end else begin
      case (pc_src)
        PC_SRC_BRANCH:            target = (alu_result == 32'd1) ? w_rel : w_seq;
        PC_SRC_JAL:               target = w_rel;
        PC_SRC_JALR:              target = w_jalr;
        PC_SRC_SEQ, PC_SRC_AUIPC: target = w_seq;
        default:                  target = w_seq;
      endcase
      misalign = is_misaligned(target);
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle PC sequencer: fetch via the IFU handshake, hold the instruction
// while execute runs, then commit the selected next PC (or trap to mtvec).
module pc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  pc_seq_ctrl_if.master   ifu,
  output logic [31:0]     inst,
  output logic            inst_valid,
  input  logic            exu_done,
  input  logic [2:0]      pc_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] ext_imm,
  input  logic            is_ecall,
  input  logic            is_mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] pc,
  output logic            commit,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_epc
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_target;
  logic            r_commit;
  logic            r_misalign;
  logic [XLEN-1:0] r_trap_epc;

  logic            w_req_valid;
  logic            w_rsp_ready;
  logic            w_inst_valid;
  logic            w_take_rsp;
  logic            w_take_exu;
  logic            w_do_upd;
  logic [XLEN-1:0] w_target;
  logic            w_misalign;

  npc_target_sel #(
    .XLEN(XLEN)
  ) u_target_sel (
    .pc         (r_pc),
    .pc_src     (pc_src),
    .alu_result (alu_result),
    .ext_imm    (ext_imm),
    .is_ecall   (is_ecall),
    .is_mret    (is_mret),
    .mtvec      (mtvec),
    .mepc       (mepc),
    .target     (w_target),
    .misalign   (w_misalign)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded handshake strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_valid  = 1'b0;
    w_rsp_ready  = 1'b0;
    w_inst_valid = 1'b0;
    w_take_rsp   = 1'b0;
    w_take_exu   = 1'b0;
    w_do_upd     = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req_valid = 1'b1;
        if (ifu.ifu_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        w_rsp_ready = 1'b1;
        if (ifu.ifu_rsp_valid) begin
          w_take_rsp  = 1'b1;
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_EXEC: begin
        w_inst_valid = 1'b1;
        if (exu_done) begin
          w_take_exu  = 1'b1;
          w_state_nxt = S_UPD;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_UPD: begin
        w_do_upd    = 1'b1;
        w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_REQ;
      end
    endcase
  end

  // Datapath: fetched instruction, latched target, PC and commit/trap pulses.
  // commit/misalign_trap/trap_epc are set on exu_done so they show during S_UPD,
  // while the old PC is still visible; the PC itself moves at the end of S_UPD.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_inst     <= 32'd0;
      r_target   <= RESET_PC;
      r_commit   <= 1'b0;
      r_misalign <= 1'b0;
      r_trap_epc <= 32'd0;
    end else begin
      r_commit   <= w_take_exu;
      r_misalign <= w_take_exu & w_misalign;
      if (w_take_rsp) begin
        r_inst <= ifu.ifu_rsp_inst;
      end
      if (w_take_exu) begin
        r_target <= w_misalign ? mtvec : w_target;
        if (w_misalign) begin
          r_trap_epc <= r_pc;
        end
      end
      if (w_do_upd) begin
        r_pc <= r_target;
      end
    end
  end

  // Strobes are forced low while reset is held so no fetch leaks out.
  assign ifu.ifu_req_valid = w_req_valid & rst;
  assign ifu.ifu_rsp_ready = w_rsp_ready & rst;
  assign ifu.ifu_req_addr  = r_pc;
  assign inst_valid        = w_inst_valid & rst;

  assign inst          = r_inst;
  assign pc            = r_pc;
  assign commit        = r_commit;
  assign misalign_trap = r_misalign;
  assign trap_epc      = r_trap_epc;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: directed cases plus randomized
// instruction streams checked against a next-PC reference model.
module tb_pc_seq_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exu_done;
  logic [2:0]  pc_src;
  logic [31:0] alu_result;
  logic [31:0] ext_imm;
  logic        is_ecall;
  logic        is_mret;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] pc;
  logic        commit;
  logic        misalign_trap;
  logic [31:0] trap_epc;

  int          n_checks;
  int          n_pass;
  logic [31:0] m_pc;

  pc_seq_ctrl_if #(.XLEN(32)) ifu ();

  pc_seq_ctrl #(
    .RESET_PC (RST_PC),
    .XLEN     (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu           (ifu.master),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .exu_done      (exu_done),
    .pc_src        (pc_src),
    .alu_result    (alu_result),
    .ext_imm       (ext_imm),
    .is_ecall      (is_ecall),
    .is_mret       (is_mret),
    .mtvec         (mtvec),
    .mepc          (mepc),
    .pc            (pc),
    .commit        (commit),
    .misalign_trap (misalign_trap),
    .trap_epc      (trap_epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference next-PC rule set, written straight from the priority list.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] src,
                                           input logic [31:0] alu, input logic [31:0] imm,
                                           input logic ecall, input logic mret,
                                           input logic [31:0] tvec, input logic [31:0] epc,
                                           output logic trap);
    logic [31:0] t;
    trap = 1'b0;
    if (ecall) return tvec;
    if (mret) return epc;
    if (src == 3'd3) t = (alu == 32'd1) ? cur + imm : cur + 32'd4;
    else if (src == 3'd1) t = cur + imm;
    else if (src == 3'd2) t = {alu[31:1], 1'b0};
    else t = cur + 32'd4;
    if ((t % 32'd4) != 32'd0) begin
      trap = 1'b1;
      return tvec;
    end
    return t;
  endfunction

  task automatic idle_inputs();
    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    ifu.ifu_rsp_inst  = 32'd0;
    exu_done   = 1'b0;
    pc_src     = 3'd0;
    alu_result = 32'd0;
    ext_imm    = 32'd0;
    is_ecall   = 1'b0;
    is_mret    = 1'b0;
    mtvec      = 32'h8000_1000;
    mepc       = 32'h8000_0040;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_req_valid", ifu.ifu_req_valid, 32'd0);
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_inst", inst, 32'd0);
    check_eq("rst_inst_valid", inst_valid, 32'd0);
    check_eq("rst_commit", commit, 32'd0);
    check_eq("rst_trap", misalign_trap, 32'd0);
    check_eq("rst_trap_epc", trap_epc, 32'd0);
    rst = 1'b1;
    #1;
    m_pc = RST_PC;
  endtask

  // One full fetch/execute/commit with the given EXU inputs and stall lengths.
  task automatic run_instr(input logic [2:0] src, input logic [31:0] alu, input logic [31:0] imm,
                           input logic ecall, input logic mret,
                           input logic [31:0] tvec, input logic [31:0] epc,
                           input int req_dly, input int rsp_dly, input int exe_dly);
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic        exp_trap;
    word   = $urandom;
    exp_pc = ref_next(m_pc, src, alu, imm, ecall, mret, tvec, epc, exp_trap);
    check_eq("req_valid", ifu.ifu_req_valid, 32'd1);
    check_eq("req_addr", ifu.ifu_req_addr, m_pc);
    for (int i = 0; i < req_dly; i++) begin
      ifu.ifu_req_ready = 1'b0;
      ifu.ifu_rsp_valid = 1'($urandom_range(0, 1));
      ifu.ifu_rsp_inst  = ~word;
      @(negedge clk);
      check_eq("stall_req_valid", ifu.ifu_req_valid, 32'd1);
      check_eq("stall_req_addr", ifu.ifu_req_addr, m_pc);
      check_eq("stall_rsp_ready", ifu.ifu_rsp_ready, 32'd0);
    end
    ifu.ifu_req_ready = 1'b1;
    ifu.ifu_rsp_valid = 1'($urandom_range(0, 1));
    ifu.ifu_rsp_inst  = ~word;
    @(negedge clk);
    ifu.ifu_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      ifu.ifu_rsp_valid = 1'b0;
      ifu.ifu_rsp_inst  = $urandom;
      check_eq("wait_rsp_ready", ifu.ifu_rsp_ready, 32'd1);
      @(negedge clk);
      check_eq("wait_inst_valid", inst_valid, 32'd0);
    end
    check_eq("rsp_ready", ifu.ifu_rsp_ready, 32'd1);
    ifu.ifu_rsp_valid = 1'b1;
    ifu.ifu_rsp_inst  = word;
    @(negedge clk);
    ifu.ifu_rsp_valid = 1'b0;
    check_eq("inst", inst, word);
    check_eq("inst_valid", inst_valid, 32'd1);
    check_eq("exec_req_valid", ifu.ifu_req_valid, 32'd0);
    for (int i = 0; i < exe_dly; i++) begin
      pc_src     = 3'($urandom);
      alu_result = $urandom;
      ext_imm    = $urandom;
      is_ecall   = 1'($urandom);
      is_mret    = 1'($urandom);
      @(negedge clk);
      check_eq("exec_hold_valid", inst_valid, 32'd1);
      check_eq("exec_no_commit", commit, 32'd0);
    end
    pc_src = src; alu_result = alu; ext_imm = imm;
    is_ecall = ecall; is_mret = mret; mtvec = tvec; mepc = epc;
    exu_done = 1'b1;
    @(negedge clk);
    exu_done = 1'b0;
    check_eq("upd_commit", commit, 32'd1);
    check_eq("upd_trap", misalign_trap, 32'(exp_trap));
    check_eq("upd_old_pc", pc, m_pc);
    check_eq("upd_inst_valid", inst_valid, 32'd0);
    if (exp_trap) check_eq("upd_trap_epc", trap_epc, m_pc);
    @(negedge clk);
    m_pc = exp_pc;
    check_eq("post_commit", commit, 32'd0);
    check_eq("post_trap", misalign_trap, 32'd0);
    check_eq("next_pc", pc, m_pc);
  endtask

  // Reset asserted while an instruction is executing, with noisy IFU responses.
  task automatic reset_in_exec();
    ifu.ifu_req_ready = 1'b1;
    @(negedge clk);
    ifu.ifu_req_ready = 1'b0;
    ifu.ifu_rsp_valid = 1'b1;
    ifu.ifu_rsp_inst  = 32'h1234_5678;
    @(negedge clk);
    ifu.ifu_rsp_valid = 1'b0;
    check_eq("pre_rst_inst_valid", inst_valid, 32'd1);
    rst      = 1'b0;
    exu_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifu.ifu_rsp_valid = 1'(i % 2 == 0);
      @(negedge clk);
      check_eq("mid_rst_pc", pc, RST_PC);
      check_eq("mid_rst_inst_valid", inst_valid, 32'd0);
      check_eq("mid_rst_commit", commit, 32'd0);
      check_eq("mid_rst_req_valid", ifu.ifu_req_valid, 32'd0);
    end
    check_eq("mid_rst_inst", inst, 32'd0);
    exu_done = 1'b0;
    ifu.ifu_rsp_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_pc = RST_PC;
    check_eq("fresh_req_valid", ifu.ifu_req_valid, 32'd1);
    check_eq("fresh_req_addr", ifu.ifu_req_addr, RST_PC);
  endtask

  initial begin
    logic [2:0]  r_src;
    logic [31:0] r_alu;
    logic [31:0] r_imm;
    logic [31:0] r_tvec;
    n_checks = 0;
    n_pass   = 0;
    m_pc     = RST_PC;
    do_reset();
    run_instr(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    check_eq("second_fetch_addr", ifu.ifu_req_addr, 32'h8000_0004);
    do_reset();
    run_instr(3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 3, 0, 0);
    do_reset();
    run_instr(3'd3, 32'd1, 32'h10, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    do_reset();
    run_instr(3'd3, 32'd0, 32'h10, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    do_reset();
    run_instr(3'd3, 32'd2, 32'h10, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    do_reset();
    run_instr(3'd2, 32'h8000_0103, 32'd0, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    check_eq("jalr_trap_pc", pc, 32'h8000_1000);
    do_reset();
    run_instr(3'd1, 32'd0, 32'd6, 1'b1, 1'b1, 32'h8000_1000, 32'h8000_0040, 0, 1, 1);
    run_instr(3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h8000_1000, 32'h8000_0040, 1, 0, 2);
    check_eq("mret_pc", pc, 32'h8000_0040);
    run_instr(3'd2, 32'hFFFF_FFFD, 32'd0, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    run_instr(3'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'h8000_1000, 32'h8000_0040, 0, 0, 0);
    check_eq("wrap_pc", pc, 32'd0);
    do_reset();
    reset_in_exec();
    for (int n = 0; n < 150; n++) begin
      r_src = 3'($urandom_range(0, 7));
      r_imm = $urandom;
      if ($urandom_range(0, 3) != 0) r_imm[1:0] = 2'b00;
      r_alu = (r_src == 3'd3) ? 32'($urandom_range(0, 2)) : $urandom;
      r_tvec = $urandom;
      if ($urandom_range(0, 7) != 0) r_tvec[1:0] = 2'b00;
      run_instr(r_src, r_alu, r_imm, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0),
                r_tvec, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
